// File: rtl/text_console_pkg.sv
// Shared constants for the text console: ASCII control codes, FSM encoding and
// display address field widths.
package text_console_pkg;

  localparam int unsigned ROW_W = 5;
  localparam int unsigned COL_W = 7;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_CLEAR_SCREEN = 2'd1;
  localparam logic [1:0] ST_CLEAR_ROW    = 2'd2;

  // Row increment that wraps at the last visible row rather than at 2**ROW_W.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] row,
                                               input logic [ROW_W-1:0] last_row);
    return (row == last_row) ? '0 : row + 5'd1;
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Character-stream input and display write-port bundle for text_console.
interface text_console_if;
  import text_console_pkg::*;

  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;
  logic             disp_en;
  logic [11:0]      disp_addr;
  logic [15:0]      disp_data;
  logic [ROW_W-1:0] cursor_row;
  logic [COL_W-1:0] cursor_col;

  modport master (
    output char_valid, char_data,
    input  char_ready, disp_en, disp_addr, disp_data, cursor_row, cursor_col
  );

  modport slave (
    input  char_valid, char_data,
    output char_ready, disp_en, disp_addr, disp_data, cursor_row, cursor_col
  );

endinterface

// File: rtl/text_console_clear_engine.sv
// Row-major sweep counter shared by the full-screen and single-row clears.
module text_console_clear_engine
  import text_console_pkg::*;
#(
  parameter int unsigned COLUMNS = 80,
  parameter int unsigned ROWS    = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [ROW_W-1:0] i_start_row,
  input  logic             i_row_only,
  input  logic             i_step,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_row_only;

  // Reset value is the start of a full-screen sweep, matching the post-reset clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_only <= 1'b0;
    end else if (i_start) begin
      r_row      <= i_start_row;
      r_col      <= '0;
      r_row_only <= i_row_only;
    end else if (i_step) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= row_inc(r_row, LAST_ROW);
      end else begin
        r_col <= r_col + 7'd1;
      end
    end
  end

  always_comb begin
    o_row  = r_row;
    o_col  = r_col;
    o_done = (r_col == LAST_COL) && (r_row_only || (r_row == LAST_ROW));
  end

endmodule

// File: rtl/text_console.sv
// Streams ASCII bytes into display memory with a hardware cursor, control-code
// decode and hardware row/screen clears.
module text_console
  import text_console_pkg::*;
#(
  parameter int unsigned COLUMNS = 80,
  parameter int unsigned ROWS    = 30,
  parameter logic [7:0]  ATTR    = 8'h0F
) (
  input logic           clk,
  input logic           rst_n,
  text_console_if.slave bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [1:0]       r_state;
  logic             r_ready;
  logic             r_en;
  logic [11:0]      r_addr;
  logic [15:0]      r_data;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  logic             w_accept;
  logic             w_printable;
  logic [ROW_W-1:0] w_next_row;
  logic             w_clr_start;
  logic [ROW_W-1:0] w_clr_row;
  logic             w_clr_row_only;
  logic             w_clr_step;
  logic [ROW_W-1:0] w_sweep_row;
  logic [COL_W-1:0] w_sweep_col;
  logic             w_clr_done;

  always_comb begin
    w_accept       = bus.char_valid & r_ready;
    w_printable    = bus.char_data >= ASCII_SPACE;
    w_next_row     = row_inc(r_row, LAST_ROW);
    w_clr_start    = w_accept && ((w_printable && (r_col == LAST_COL)) ||
                                  (bus.char_data == ASCII_LF) || (bus.char_data == ASCII_FF));
    w_clr_row      = (bus.char_data == ASCII_FF) ? '0 : w_next_row;
    w_clr_row_only = (bus.char_data != ASCII_FF);
    w_clr_step     = (r_state != ST_IDLE);
  end

  text_console_clear_engine #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS)
  ) u_clear (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_clr_start),
    .i_start_row (w_clr_row),
    .i_row_only  (w_clr_row_only),
    .i_step      (w_clr_step),
    .o_row       (w_sweep_row),
    .o_col       (w_sweep_col),
    .o_done      (w_clr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR_SCREEN;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_en <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          if (w_printable) begin
            r_en   <= 1'b1;
            r_addr <= {r_row, r_col};
            r_data <= {ATTR, bus.char_data};
            if (r_col == LAST_COL) begin
              r_col   <= '0;
              r_row   <= w_next_row;
              r_state <= ST_CLEAR_ROW;
              r_ready <= 1'b0;
            end else begin
              r_col <= r_col + 7'd1;
            end
          end else begin
            case (bus.char_data)
              ASCII_LF: begin
                r_col   <= '0;
                r_row   <= w_next_row;
                r_state <= ST_CLEAR_ROW;
                r_ready <= 1'b0;
              end
              ASCII_CR: r_col <= '0;
              ASCII_BS: begin
                if (r_col != '0) begin
                  r_col  <= r_col - 7'd1;
                  r_en   <= 1'b1;
                  r_addr <= {r_row, r_col - 7'd1};
                  r_data <= {ATTR, ASCII_SPACE};
                end
              end
              ASCII_FF: begin
                r_col   <= '0;
                r_row   <= '0;
                r_state <= ST_CLEAR_SCREEN;
                r_ready <= 1'b0;
              end
              default: ;
            endcase
          end
        end
      end else begin
        // Cursor already holds its post-clear target; only the sweep moves here.
        r_en   <= 1'b1;
        r_addr <= {w_sweep_row, w_sweep_col};
        r_data <= {ATTR, ASCII_SPACE};
        if (w_clr_done) begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.char_ready = r_ready;
    bus.disp_en    = r_en;
    bus.disp_addr  = r_addr;
    bus.disp_data  = r_data;
    bus.cursor_row = r_row;
    bus.cursor_col = r_col;
  end

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console with a 4x2 screen.
module tb_text_console;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   low_cnt = 0;

  logic [11:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];

  text_console_if bus ();

  text_console #(
    .COLUMNS (4),
    .ROWS    (2),
    .ATTR    (8'h0F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.disp_en) begin
        log_addr.push_back(bus.disp_addr);
        log_data.push_back(bus.disp_data);
        log_cyc.push_back(cyc);
      end
      if (!bus.char_ready) low_cnt++;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    low_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); #1;
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    @(negedge clk); #1;
    bus.char_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.char_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.char_ready) begin
      errors++;
      $display("FAIL %s_ready_timeout: char_ready=%b after %0d cycles, required 1",
               name, bus.char_ready, n);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] exp_addr[8];
    exp_addr = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h080, 12'h081, 12'h082, 12'h083};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.disp_en, bus.disp_addr, bus.disp_data, bus.char_ready} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b addr=%h data=%h ready=%b, required all 0",
               bus.disp_en, bus.disp_addr, bus.disp_data, bus.char_ready);
    end
    checks++;
    if ({bus.cursor_row, bus.cursor_col} !== 12'd0) begin
      errors++;
      $display("FAIL reset_cursor: got (%0d,%0d), required (0,0)", bus.cursor_row, bus.cursor_col);
    end
    #1;
    clear_log();
    rst_n = 1'b1;
    wait_ready("reset");
    checks++;
    if (log_addr.size() != 8) begin
      errors++;
      $display("FAIL reset_clear_count: got %0d writes, required 8", log_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== 16'h0F20) begin
          errors++;
          $display("FAIL reset_clear_%0d: got %h@%h, required 0f20@%h",
                   i, log_data[i], log_addr[i], exp_addr[i]);
        end
      end
    end
    checks++;
    if ({bus.cursor_row, bus.cursor_col} !== 12'd0) begin
      errors++;
      $display("FAIL reset_cursor_after: got (%0d,%0d), required (0,0)",
               bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    @(negedge clk); #1;
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h41;
    @(negedge clk); #1;
    bus.char_data  = 8'h42;
    @(negedge clk); #1;
    bus.char_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (log_addr.size() != 2) begin
      errors++;
      $display("FAIL ab_count: got %0d writes, required 2", log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 12'h000 || log_data[0] !== 16'h0F41) begin
        errors++;
        $display("FAIL ab_first: got %h@%h, required 0f41@000", log_data[0], log_addr[0]);
      end
      checks++;
      if (log_addr[1] !== 12'h001 || log_data[1] !== 16'h0F42) begin
        errors++;
        $display("FAIL ab_second: got %h@%h, required 0f42@001", log_data[1], log_addr[1]);
      end
      checks++;
      if (log_cyc[1] - log_cyc[0] != 1) begin
        errors++;
        $display("FAIL ab_consecutive: got gap %0d, required 1", log_cyc[1] - log_cyc[0]);
      end
    end
    checks++;
    if (bus.cursor_col !== 7'd2 || low_cnt != 0) begin
      errors++;
      $display("FAIL ab_cursor_ready: got col=%0d ready_low=%0d, required col=2 ready_low=0",
               bus.cursor_col, low_cnt);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    send_byte(8'h43);
    wait_ready("wrap_c");
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 12'h002 || log_data[0] !== 16'h0F43) begin
      errors++;
      $display("FAIL wrap_c_write: got %0d writes, first %h@%h, required 0f43@002",
               log_addr.size(), log_data[0], log_addr[0]);
    end
    clear_log();
    send_byte(8'h5A);
    wait_ready("wrap_z");
    checks++;
    if (log_addr.size() != 5) begin
      errors++;
      $display("FAIL wrap_count: got %0d writes, required 5", log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 12'h003 || log_data[0] !== 16'h0F5A) begin
        errors++;
        $display("FAIL wrap_char: got %h@%h, required 0f5a@003", log_data[0], log_addr[0]);
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (log_addr[i] !== 12'(12'h07F + i) || log_data[i] !== 16'h0F20 ||
            log_cyc[i] - log_cyc[i-1] != 1) begin
          errors++;
          $display("FAIL wrap_clear_%0d: got %h@%h gap %0d, required 0f20@%h gap 1",
                   i, log_data[i], log_addr[i], log_cyc[i] - log_cyc[i-1], 12'(12'h07F + i));
        end
      end
    end
    checks++;
    if (low_cnt != 4) begin
      errors++;
      $display("FAIL wrap_ready_low: got %0d cycles, required 4", low_cnt);
    end
    checks++;
    if (bus.cursor_row !== 5'd1 || bus.cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL wrap_cursor: got (%0d,%0d), required (1,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_lf_wrap();
    send_byte(8'h61);
    wait_ready("lf_a");
    send_byte(8'h62);
    wait_ready("lf_b");
    clear_log();
    send_byte(8'h0A);
    wait_ready("lf");
    checks++;
    if (log_addr.size() != 4) begin
      errors++;
      $display("FAIL lf_count: got %0d writes, required 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[i] !== 12'(i) || log_data[i] !== 16'h0F20) begin
          errors++;
          $display("FAIL lf_clear_%0d: got %h@%h, required 0f20@%h",
                   i, log_data[i], log_addr[i], 12'(i));
        end
      end
    end
    checks++;
    if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL lf_cursor: got (%0d,%0d), required (0,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_backspace();
    send_byte(8'h78);
    wait_ready("bs_x");
    send_byte(8'h79);
    wait_ready("bs_y");
    clear_log();
    send_byte(8'h08);
    wait_ready("bs");
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 12'h001 || log_data[0] !== 16'h0F20) begin
      errors++;
      $display("FAIL bs_write: got %0d writes, first %h@%h, required one 0f20@001",
               log_addr.size(), log_data[0], log_addr[0]);
    end
    checks++;
    if (bus.cursor_col !== 7'd1 || bus.cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL bs_cursor: got (%0d,%0d), required (0,1)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_noops();
    logic [7:0] codes[4];
    codes = '{8'h0D, 8'h08, 8'h07, 8'h0D};
    send_byte(codes[0]);
    wait_ready("noop_cr");
    clear_log();
    for (int i = 1; i < 4; i++) begin
      send_byte(codes[i]);
      wait_ready("noop");
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (log_addr.size() != 0 || low_cnt != 0) begin
      errors++;
      $display("FAIL noop_writes: got %0d writes ready_low=%0d, required 0 and 0",
               log_addr.size(), low_cnt);
    end
    checks++;
    if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL noop_cursor: got (%0d,%0d), required (0,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_form_feed();
    send_byte(8'h71);
    wait_ready("ff_q");
    clear_log();
    send_byte(8'h0C);
    wait_ready("ff");
    checks++;
    if (log_addr.size() != 8 || log_addr[0] !== 12'h000 || log_addr[7] !== 12'h083) begin
      errors++;
      $display("FAIL ff_clear: got %0d writes first@%h last@%h, required 8 000..083",
               log_addr.size(), log_addr[0], log_addr[log_addr.size()-1]);
    end
    checks++;
    if (bus.cursor_row !== 5'd0 || bus.cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL ff_cursor: got (%0d,%0d), required (0,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_reset_mid_clear();
    send_byte(8'h0A);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.disp_en, bus.disp_addr, bus.disp_data, bus.char_ready} !== 30'd0 ||
        {bus.cursor_row, bus.cursor_col} !== 12'd0) begin
      errors++;
      $display("FAIL midreset_outputs: en=%b addr=%h data=%h ready=%b cur=(%0d,%0d), required 0",
               bus.disp_en, bus.disp_addr, bus.disp_data, bus.char_ready,
               bus.cursor_row, bus.cursor_col);
    end
    clear_log();
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_ready("midreset");
    checks++;
    if (log_addr.size() != 8 || log_addr[0] !== 12'h000 || log_addr[7] !== 12'h083 ||
        log_data[0] !== 16'h0F20) begin
      errors++;
      $display("FAIL midreset_restart: got %0d writes first %h@%h, required 8 from 0f20@000",
               log_addr.size(), log_data[0], log_addr[0]);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_lf_wrap();
    test_backspace();
    test_noops();
    test_form_feed();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
